alu_md: RTL and testbench
=========================

// Module: alu_md
// PURPOSE
//  Parametrised execute-stage ALU with a sequential multiply/divide unit and HI/LO registers.
//  Combinational path computes C/Zero every cycle, as the single-cycle datapath requires.
//  MD path runs MULT/MULTU/DIV/DIVU iteratively under a start/busy/done handshake.
//  MTHI/MTLO write HI/LO directly. The controller stalls the pipeline while md_busy=1.
// PARAMETERS
//  WIDTH    32                Datapath width; even, >=8.
//  SHW      $clog2(WIDTH)     Shift-amount width (derived; do not override).
// PORTS
//  clk       in   1        Clock; all state updates on rising edge.
//  rst       in   1        Synchronous, active-high reset.
//  A         in   WIDTH    Operand A (rs).
//  B         in   WIDTH    Operand B (rt / extended immediate).
//  shamt     in   SHW      Immediate shift amount.
//  ALUOp     in   4        Combinational op; ALU_* codes from ctrl_encode_def.v.
//  C         out  WIDTH    Combinational result.
//  Zero      out  1        C == 0.
//  md_op     in   3        000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x none.
//  md_start  in   1        Request; sampled on clk edge.
//  md_busy   out  1        MD operation in flight.
//  md_done   out  1        One-cycle pulse; HI/LO valid this cycle.
//  hi, lo    out  WIDTH    HI/LO registers (MFHI/MFLO read these directly).
// BEHAVIOUR
//  Combinational: NOP/ADD/SUB/AND/OR/NOR/XOR/SLT (signed)/SLTU/SLL/SRL/SLLV/LUI (B<<16)
//   plus new ALU_SRA (B>>>shamt), ALU_SRLV, ALU_SRAV (amount = A[SHW-1:0]). Undefined op -> C=A.
//   Wrap-around on ADD/SUB; no overflow flag. C/Zero are independent of MD state.
//  Reset: md_busy=0, md_done=0, hi=0, lo=0, FSM=IDLE. rst has priority over md_start.
//  FSM: IDLE -> RUN -> FIX -> IDLE.
//   IDLE: md_start with md_op in {MULT..DIVU}: latch A, B, and op; load counter=WIDTH-1; go RUN.
//         Set md_busy=1 from the next cycle.
//   RUN: one radix-2 step per cycle (shift-add multiply / restoring divide on magnitudes).
//        Stays WIDTH cycles; go FIX when counter reaches 0.
//   FIX: apply sign correction; write hi/lo on the exiting edge; go IDLE.
//        md_done=1 and md_busy=0 in the cycle after that edge.
//  Latency: start sampled at edge E0 -> hi/lo written at E(WIDTH+1).
//   md_busy is high from E0 to E(WIDTH+1); md_done is high for exactly one cycle after E(WIDTH+1).
//  MULT/MULTU: {hi,lo} = 2*WIDTH-bit signed/unsigned product.
//  DIV/DIVU: lo = quotient truncated toward zero; hi = remainder, which takes the dividend's sign.
//  Divide by zero: hi=A, lo=all-ones; same latency.
//  DIV most-negative/-1: lo=most-negative, hi=0.
//  MTHI/MTLO in IDLE: hi (or lo)=A at E0; md_busy stays 0; md_done pulses one cycle after E0.
//  md_start while md_busy=1: ignored; no queueing; in-flight op unaffected.
//  md_start with md_op=11x: ignored.
//  Operands are latched at start: A/B changes during RUN have no effect.
//  rst mid-operation: aborts; outputs take reset values; no md_done pulse.
// CONFIGURATION
//  ALU_MD_FAST_MUL_EN defined: MULT/MULTU go IDLE->FIX using a single-cycle WIDTHxWIDTH multiply.
//   hi/lo are written at E1; md_busy is high for one cycle; md_done follows E1.
//   DIV/DIVU are unchanged.
//  ALU_MD_FAST_MUL_EN undefined: every MULT/MULTU takes the iterative WIDTH+1 latency.
// TESTING (WIDTH=32)
//  MULT A=0xFFFFFFFD (-3), B=7 -> at E33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; md_done high exactly 1 cycle.
//  DIVU 100/7 -> lo=14, hi=2.
//  DIV 0xFFFFFFF9/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIV 5/0 -> hi=5, lo=0xFFFFFFFF.
//  DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  Second md_start at E5 of a MULTU -> ignored; result matches the first op.
//  rst at E10 -> next cycle busy=0, hi=lo=0; no md_done.
//  Comb: SRA B=0x80000000, shamt=4 -> C=0xF8000000, Zero=0.
//  Comb: SUB 5-5 -> C=0, Zero=1. Comb: SRAV A=36 -> shift by 4.
//  MTLO A=0x1234 -> lo=0x1234 at E0; md_busy never 1; md_done one pulse.
//  ALU_MD_FAST_MUL_EN: MULTU 0xFFFFFFFF*2 -> hi=1, lo=0xFFFFFFFE at E1.
//  Without ALU_MD_FAST_MUL_EN, the same op completes at E33.

Source files
------------

// File: rtl/alu_md.sv
// Execute-stage ALU (combinational C/Zero) plus iterative multiply/divide unit with HI/LO registers.
// Optional ALU_MD_FAST_MUL_EN: MULT/MULTU finish in one step through a full-width multiplier.
module alu_md #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [SHW-1:0]   shamt,
    input  logic [3:0]       ALUOp,
    output logic [WIDTH-1:0] C,
    output logic             Zero,
    input  logic [2:0]       md_op,
    input  logic             md_start,
    output logic             md_busy,
    output logic             md_done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_NOR  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_SLL  = 4'd9;
    localparam logic [3:0] ALU_SRL  = 4'd10;
    localparam logic [3:0] ALU_SLLV = 4'd11;
    localparam logic [3:0] ALU_LUI  = 4'd12;
    localparam logic [3:0] ALU_SRA  = 4'd13;
    localparam logic [3:0] ALU_SRLV = 4'd14;
    localparam logic [3:0] ALU_SRAV = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [SHW-1:0]     vamt;
    logic               start_a_neg, start_b_neg;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // ---------------- combinational ALU ----------------
    assign vamt = A[SHW-1:0];

    always_comb begin
        C = A;
        case (ALUOp)
            ALU_NOP:  C = A;
            ALU_ADD:  C = A + B;
            ALU_SUB:  C = A - B;
            ALU_AND:  C = A & B;
            ALU_OR:   C = A | B;
            ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
            ALU_NOR:  C = ~(A | B);
            ALU_XOR:  C = A ^ B;
            ALU_SLL:  C = B << shamt;
            ALU_SRL:  C = B >> shamt;
            ALU_SLLV: C = B << vamt;
            ALU_LUI:  C = B << 16;
            ALU_SRA:  C = $unsigned($signed(B) >>> shamt);
            ALU_SRLV: C = B >> vamt;
            ALU_SRAV: C = $unsigned($signed(B) >>> vamt);
            default:  C = A;
        endcase
    end

    assign Zero = (C == '0);

    // ---------------- multiply / divide unit ----------------
    // Both iterations work on magnitudes; signs are reapplied in FIX.
    assign start_a_neg = ~md_op[0] & A[WIDTH-1];
    assign start_b_neg = ~md_op[0] & B[WIDTH-1];

    assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    assign div_trial = {acc_q, q_q[WIDTH-1]} - {1'b0, m_q};

`ifdef ALU_MD_FAST_MUL_EN
    assign prod_mag = {{WIDTH{1'b0}}, m_q} * {{WIDTH{1'b0}}, q_q};
`else
    assign prod_mag = {acc_q, q_q};
`endif

    assign prod_fix = (a_neg_q ^ b_neg_q) ? -prod_mag : prod_mag;
    assign quo_fix  = (a_neg_q ^ b_neg_q) ? -q_q : q_q;
    assign rem_fix  = a_neg_q ? -acc_q : acc_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        a_neg_d = a_neg_q;
        b_neg_d = b_neg_q;
        a_d     = a_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (md_start && !md_op[2]) begin
                    div_d   = md_op[1];
                    a_neg_d = start_a_neg;
                    b_neg_d = start_b_neg;
                    a_d     = A;
                    q_d     = start_a_neg ? -A : A;
                    m_d     = start_b_neg ? -B : B;
                    acc_d   = '0;
                    cnt_d   = SHW'(WIDTH - 1);
                    state_d = S_RUN;
`ifdef ALU_MD_FAST_MUL_EN
                    if (!md_op[1]) state_d = S_FIX;
`endif
                end else if (md_start && !md_op[1]) begin
                    if (md_op[0]) lo_d = A;
                    else          hi_d = A;
                    done_d = 1'b1;
                end
            end
            S_RUN: begin
                if (div_q) begin
                    // Restoring step: keep the trial remainder only when it did not borrow.
                    if (!div_trial[WIDTH]) begin
                        acc_d = div_trial[WIDTH-1:0];
                        q_d   = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = {acc_q[WIDTH-2:0], q_q[WIDTH-1]};
                        q_d   = {q_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    if (m_q == '0) begin
                        hi_d = a_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            a_neg_q <= 1'b0;
            b_neg_q <= 1'b0;
            a_q     <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            a_neg_q <= a_neg_d;
            b_neg_q <= b_neg_d;
            a_q     <= a_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign md_busy = (state_q != S_IDLE);
    assign md_done = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;

endmodule

// File: tb/tb_alu_md.sv
// Randomized bench for alu_md (WIDTH=32) against a plain-arithmetic reference model.
module tb_alu_md;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  A, B, C, hi, lo;
    logic [4:0]    shamt;
    logic [3:0]    ALUOp;
    logic          Zero;
    logic [2:0]    md_op;
    logic          md_start, md_busy, md_done;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    alu_md #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .A(A), .B(B), .shamt(shamt), .ALUOp(ALUOp),
        .C(C), .Zero(Zero), .md_op(md_op), .md_start(md_start),
        .md_busy(md_busy), .md_done(md_done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference: ALU op codes 0..15 = NOP ADD SUB AND OR SLT SLTU NOR XOR SLL SRL SLLV LUI SRA SRLV SRAV
    function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, b,
                                              input logic [4:0] sh);
        logic signed [31:0] sb;
        logic [4:0] va;
        sb = b;
        va = a[4:0];
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6:    return (a < b) ? 32'd1 : 32'd0;
            4'd7:    return ~(a | b);
            4'd8:    return a ^ b;
            4'd9:    return b << sh;
            4'd10:   return b >> sh;
            4'd11:   return b << va;
            4'd12:   return {b[15:0], 16'h0};
            4'd13:   return sb >>> sh;
            4'd14:   return b >> va;
            4'd15:   return sb >>> va;
            default: return a;
        endcase
    endfunction

    // Returns {hi, lo}.
    function automatic logic [63:0] md_model(input logic [2:0] op, input logic [31:0] a, b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return {32'h0, a} * {32'h0, b};
            3'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                q = sa / sb;
                r = sa % sb;
                qv = q;
                rv = r;
                return {rv[31:0], qv[31:0]};
            end
            3'd3: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic comb_chk(input string tag, input logic [3:0] op, input logic [31:0] a, b,
                            input logic [4:0] sh);
        logic [31:0] e;
        @(negedge clk);
        ALUOp = op; A = a; B = b; shamt = sh;
        #1;
        e = alu_model(op, a, b, sh);
        check({tag, " C"}, 64'(C), 64'(e));
        check({tag, " Zero"}, 64'(Zero), 64'(e == 0));
    endtask

    task automatic md_run(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                          input bit restart);
        int k, busy_low, exp_lat;
        logic [63:0] e;
        e = md_model(op, a, b);
        exp_lat = W + 1;
`ifdef ALU_MD_FAST_MUL_EN
        if (!op[1]) exp_lat = 1;
`endif
        @(negedge clk);
        A = a; B = b; md_op = op; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        k = 0;
        busy_low = 0;
        while (!md_done && k < 200) begin
            if (!md_busy) busy_low++;
            A = $urandom;
            B = $urandom;
            if (restart && k == 4) begin
                md_start = 1'b1;
                md_op = 3'b011;
            end
            if (restart && k == 5) md_start = 1'b0;
            @(posedge clk); #1;
            k++;
        end
        md_start = 1'b0;
        check({tag, " latency"}, 64'(k), 64'(exp_lat));
        check({tag, " busy gaps"}, 64'(busy_low), 64'd0);
        check({tag, " hi"}, 64'(hi), 64'(e[63:32]));
        check({tag, " lo"}, 64'(lo), 64'(e[31:0]));
        check({tag, " busy at done"}, 64'(md_busy), 64'd0);
        @(posedge clk); #1;
        check({tag, " done pulse width"}, 64'(md_done), 64'd0);
    endtask

    task automatic mt_run(input string tag, input logic is_lo, input logic [31:0] a);
        logic [31:0] other;
        other = is_lo ? hi : lo;
        @(negedge clk);
        A = a; md_op = is_lo ? 3'b101 : 3'b100; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        check({tag, " value"}, 64'(is_lo ? lo : hi), 64'(a));
        check({tag, " other kept"}, 64'(is_lo ? hi : lo), 64'(other));
        check({tag, " busy"}, 64'(md_busy), 64'd0);
        check({tag, " done"}, 64'(md_done), 64'd1);
        @(posedge clk); #1;
        check({tag, " done clears"}, 64'(md_done), 64'd0);
        check({tag, " busy after"}, 64'(md_busy), 64'd0);
    endtask

    initial begin
        logic [31:0] h0, l0;
        int k, dones;

        rst = 1'b1; A = '0; B = '0; shamt = '0; ALUOp = '0; md_op = 3'b111; md_start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        A = 32'd5; B = 32'd3; md_op = 3'b000; md_start = 1'b1;
        @(posedge clk); #1;
        check("reset busy", 64'(md_busy), 64'd0);
        check("reset done", 64'(md_done), 64'd0);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        md_start = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        comb_chk("SRA", 4'd13, 32'h0, 32'h8000_0000, 5'd4);
        comb_chk("SUB zero", 4'd2, 32'd5, 32'd5, 5'd0);
        comb_chk("SRAV", 4'd15, 32'd36, 32'h8000_0000, 5'd0);
        for (int i = 0; i < 40; i++)
            comb_chk("comb rand", 4'($urandom_range(0, 15)), pick_operand(), pick_operand(),
                     5'($urandom));

        md_run("MULT -3*7", 3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
        md_run("DIVU 100/7", 3'd3, 32'd100, 32'd7, 1'b0);
        md_run("DIV -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
        md_run("DIV 5/0", 3'd2, 32'd5, 32'd0, 1'b0);
        md_run("DIV min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_run("MULTU restart", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        md_run("MULTU max*2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);

        mt_run("MTLO", 1'b1, 32'h1234);
        mt_run("MTHI", 1'b0, 32'hCAFE_0001);

        h0 = hi; l0 = lo;
        @(negedge clk);
        md_op = 3'b110; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        check("op 11x busy", 64'(md_busy), 64'd0);
        check("op 11x done", 64'(md_done), 64'd0);
        @(posedge clk); #1;
        check("op 11x hi", 64'(hi), 64'(h0));
        check("op 11x lo", 64'(lo), 64'(l0));

        for (int i = 0; i < 12; i++)
            md_run("md rand", 3'($urandom_range(0, 3)), pick_operand(), pick_operand(), 1'b0);

        // Abort a divide with reset at E10.
        @(negedge clk);
        A = 32'hDEAD_BEEF; B = 32'd3; md_op = 3'b011; md_start = 1'b1;
        @(posedge clk); #1;
        md_start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort busy", 64'(md_busy), 64'd0);
        check("abort hi", 64'(hi), 64'd0);
        check("abort lo", 64'(lo), 64'd0);
        check("abort done", 64'(md_done), 64'd0);
        dones = 0;
        for (k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (md_done) dones++;
        end
        check("abort no done", 64'(dones), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
